// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider: per-channel square wave, tick, shadowed divisor, glitch-free stop.
// Optional realignment input SyncIn is built when CLKDIV_SYNC_EN is defined.

module clk_div_ch #(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pend,
    output logic             run
);
    logic [CNT_W-1:0] cnt, div, shadow;
    logic             at_end;

    assign at_end = (cnt == div);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt     <= '0;
            div     <= CNT_W'(DEF_DIV);
            shadow  <= CNT_W'(DEF_DIV);
            pend    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            run     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!run) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                run     <= en;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
`ifdef CLKDIV_SYNC_EN
            end else if (sync) begin
                // Realign: may cut a high phase short; no tick is produced.
                cnt     <= '0;
                clk_out <= 1'b0;
                run     <= en;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
`endif
            end else if (!en && !clk_out) begin
                cnt <= '0;
                run <= 1'b0;
            end else if (at_end) begin
                // Toggle cycle; a stop request only reaches here while high, so it ends low.
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                run     <= en;
                if (pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A write lands after any apply this cycle, so it waits for the next one.
            if (wr) begin
                shadow <= wr_div;
                pend   <= 1'b1;
            end
        end
    end
endmodule

module clk_div_bank #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 5,
    parameter int SEL_W   = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NUM_CH-1:0] En,
    input  logic              WrEn,
    input  logic [SEL_W-1:0]  WrSel,
    input  logic [CNT_W-1:0]  WrDiv,
`ifdef CLKDIV_SYNC_EN
    input  logic              SyncIn,
`endif
    output logic [NUM_CH-1:0] ClkOut,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Pend,
    output logic [NUM_CH-1:0] Run
);
    logic [NUM_CH-1:0] wr_hit;

    // Out-of-range selects match no channel and are dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            wr_hit[i] = WrEn && (32'(WrSel) == 32'(i));
    end

    clk_div_ch #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_ch [NUM_CH-1:0] (
        .Clk     (Clk),
        .Rst     (Rst),
        .en      (En),
        .wr      (wr_hit),
        .wr_div  (WrDiv),
`ifdef CLKDIV_SYNC_EN
        .sync    (SyncIn),
`endif
        .clk_out (ClkOut),
        .tick    (Tick),
        .pend    (Pend),
        .run     (Run)
    );
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a 4-channel and a 3-channel instance share stimulus.
module tb_clk_div_bank;
    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] En;
    logic       WrEn;
    logic [1:0] WrSel;
    logic [7:0] WrDiv;
`ifdef CLKDIV_SYNC_EN
    logic       SyncIn;
`endif
    logic [3:0] ClkOut, Tick, Pend, Run;
    logic [2:0] ClkOut3, Tick3, Pend3, Run3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    clk_div_bank #(.NUM_CH(4), .CNT_W(8), .DEF_DIV(5), .SEL_W(2)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .WrEn(WrEn), .WrSel(WrSel), .WrDiv(WrDiv),
`ifdef CLKDIV_SYNC_EN
        .SyncIn(SyncIn),
`endif
        .ClkOut(ClkOut), .Tick(Tick), .Pend(Pend), .Run(Run)
    );

    clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(5), .SEL_W(2)) dut3 (
        .Clk(Clk), .Rst(Rst), .En(En[2:0]), .WrEn(WrEn), .WrSel(WrSel), .WrDiv(WrDiv),
`ifdef CLKDIV_SYNC_EN
        .SyncIn(SyncIn),
`endif
        .ClkOut(ClkOut3), .Tick(Tick3), .Pend(Pend3), .Run(Run3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; En = '0; WrEn = 1'b0; WrSel = '0; WrDiv = '0;
`ifdef CLKDIV_SYNC_EN
        SyncIn = 1'b0;
`endif
        cyc(); cyc();
        Rst = 1'b0;
        chk("rst clkout", {ClkOut, ClkOut3}, 7'h0);
        chk("rst tick",   {Tick, Tick3},     7'h0);
        chk("rst pend",   {Pend, Pend3},     7'h0);
        chk("rst run",    {Run, Run3},       7'h0);

        // Ch0 at default divisor 5: 6 low / 6 high.
        En = 4'b0001;
        cyc();
        chk("t1 run", Run, 4'b0001);
        for (int k = 1; k <= 24; k++) begin
            cyc();
            chk("t1 clkout", ClkOut, {3'b0, ((k / 6) % 2) == 1});
            chk("t1 tick",   Tick,   {3'b0, (k % 12) == 6});
        end

        // Stop two cycles into the high half: 4 more high cycles, then idle.
        repeat (7) cyc();
        chk("t3 high", ClkOut[0], 1'b1);
        En = 4'b0000;
        for (int k = 32; k <= 40; k++) begin
            cyc();
            chk("t3 clkout", ClkOut[0], k < 36);
            chk("t3 run",    Run[0],    k < 36);
            chk("t3 tick",   Tick[0],   1'b0);
        end

        // Divisor write mid-high-phase applies only at the end of that half.
        En = 4'b0001;
        cyc();
        chk("t2 run", Run, 4'b0001);
        repeat (7) cyc();
        chk("t2 high", ClkOut[0], 1'b1);
        WrEn = 1'b1; WrSel = 2'd0; WrDiv = 8'd2;
        cyc();
        WrEn = 1'b0;
        chk("t2 pend set", Pend, 4'b0001);
        repeat (3) cyc();
        chk("t2 half held", {ClkOut[0], Pend[0]}, 2'b11);
        for (int j = 0; j < 12; j++) begin
            cyc();
            chk("t2 clkout", ClkOut[0], ((j / 3) % 2) == 1);
            chk("t2 tick",   Tick[0],   (j % 6) == 3);
            chk("t2 pend",   Pend[0],   1'b0);
        end

        // Divisor 0 on idle ch1: applied next cycle, then Clk/2.
        WrEn = 1'b1; WrSel = 2'd1; WrDiv = 8'd0;
        cyc();
        WrEn = 1'b0;
        chk("t4 pend set", Pend, 4'b0010);
        En = 4'b0011;
        cyc();
        chk("t4 pend clr", Pend[1], 1'b0);
        chk("t4 run",      Run[1],  1'b1);
        for (int j = 1; j <= 8; j++) begin
            cyc();
            chk("t4 clkout", ClkOut[1], j % 2);
            chk("t4 tick",   Tick[1],   j % 2);
        end
        En = 4'b0000;
        repeat (20) cyc();
        chk("t4 all idle", {Run, Run3, ClkOut, ClkOut3}, 14'h0);

        // Back-to-back writes to running ch2 (last wins), plus out-of-range select for dut3.
        En = 4'b0100;
        cyc();
        chk("t5 run", Run3, 3'b100);
        WrEn = 1'b1; WrSel = 2'd2; WrDiv = 8'd7;
        cyc();
        WrDiv = 8'd3;
        cyc();
        WrSel = 2'd3; WrDiv = 8'd9;
        cyc();
        WrEn = 1'b0;
        chk("t5 pend3", Pend3, 3'b100);
        chk("t5 pend4", Pend, 4'b1100);
        for (int r = 4; r <= 14; r++) begin
            cyc();
            chk("t5 clkout3", ClkOut3[2], (r >= 6 && r < 10) || r >= 14);
            chk("t5 clkout4", ClkOut[2],  (r >= 6 && r < 10) || r >= 14);
            chk("t5 tick3",   Tick3[2],   r == 6 || r == 14);
            chk("t5 pend3",   Pend3,      (r >= 6) ? 3'b000 : 3'b100);
        end
        chk("t5 run3", Run3, 3'b100);

        // Reset mid-period with a pending write; divisor returns to 5.
        WrEn = 1'b1; WrSel = 2'd2; WrDiv = 8'd1;
        cyc();
        WrEn = 1'b0;
        chk("t6 pend", Pend[2], 1'b1);
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        chk("t6 zero", {ClkOut, Tick, Pend, Run}, 16'h0);
        chk("t6 zero3", {ClkOut3, Tick3, Pend3, Run3}, 12'h0);
        cyc();
        chk("t6 run", Run, 4'b0100);
        repeat (5) cyc();
        chk("t6 low", ClkOut[2], 1'b0);
        cyc();
        chk("t6 rise", {ClkOut[2], Tick[2]}, 2'b11);

`ifdef CLKDIV_SYNC_EN
        cyc();
        SyncIn = 1'b1;
        cyc();
        SyncIn = 1'b0;
        chk("sync realign", {ClkOut[2], Tick[2], Run[2]}, 3'b001);
        repeat (5) cyc();
        chk("sync low", ClkOut[2], 1'b0);
        cyc();
        chk("sync rise", {ClkOut[2], Tick[2]}, 2'b11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock divider. It is the parametrised successor to the fixed single-output divider.
- Each channel derives a divided square wave and a one-cycle tick (clock-enable) from Clk.
- Each channel has its own runtime-loadable divisor, a glitch-free enable and a pending-update status.
- Sits at top level and feeds slow clocks/enables to display, debounce and single-step logic.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 8, width of divisor and per-channel counter
DEF_DIV, 5, reset divisor for every channel (must fit in CNT_W bits)
SEL_W, 2, width of WrSel (ceil(log2(NUM_CH)), minimum 1)

Ports:
Clk  in  1  system clock; all logic on rising edge
Rst  in  1  synchronous, active-high reset
En  in  NUM_CH  per-channel run enable
WrEn  in  1  divisor write strobe, single cycle
WrSel  in  SEL_W  channel index for write
WrDiv  in  CNT_W  new divisor value
ClkOut  out  NUM_CH  divided square wave per channel, registered
Tick  out  NUM_CH  one-cycle pulse coincident with first high cycle of ClkOut[ch]
Pend  out  NUM_CH  1 = shadow divisor written but not yet applied
Run  out  NUM_CH  1 = channel actively counting

Behaviour:
- Reset (Rst=1 at a rising edge):
  - ClkOut=0, Tick=0, Pend=0, Run=0.
  - Cnt[ch]=0; Div[ch]=Shadow[ch]=DEF_DIV.
  - Rst overrides En, WrEn and SyncIn, including mid-period.
- Per-channel states: IDLE (Run=0) and RUN (Run=1).
- IDLE:
  - Cnt=0, ClkOut=0, Tick=0.
  - When En[ch]=1, go to RUN next cycle with Cnt starting at 0.
- RUN, counting:
  - If Cnt==Div: ClkOut toggles, Cnt<=0 (a "toggle cycle").
  - Else: Cnt<=Cnt+1, ClkOut holds.
  - Half period = Div+1 cycles; full period = 2*(Div+1) cycles.
  - First rising edge of ClkOut occurs Div+1 cycles after Run rises.
- Tick:
  - Registered alongside ClkOut; Tick<=1 exactly when the toggle takes ClkOut 0->1.
  - One cycle wide, once per period.
- Div=0: ClkOut toggles every cycle (Clk/2); Tick is every other cycle.
- Counter arithmetic: unsigned CNT_W bits. Cnt never exceeds Div, so no wrap occurs.
- Divisor write (WrEn=1):
  - Shadow[WrSel]<=WrDiv and Pend[WrSel]<=1.
  - WrSel>=NUM_CH: ignored, no state change.
  - A write while Pend=1 overwrites the shadow; last write wins.
- Divisor apply:
  - RUN: Div<=Shadow and Pend<=0 on the next toggle cycle, so a half period is never truncated.
  - IDLE: Div<=Shadow and Pend<=0 on the next cycle.
  - A write in the same cycle as a toggle does not affect that toggle; it applies at the following toggle.
- Glitch-free stop (En[ch]=0 while RUN):
  - If ClkOut=1, the channel finishes the high half, then drops ClkOut to 0 at the toggle and enters IDLE.
  - If ClkOut=0, the channel enters IDLE next cycle.
  - Re-asserting En before the stop completes cancels the stop.
- Channels are fully independent; no cross-channel ordering is implied.

Optional Feature:
Macro: CLKDIV_SYNC_EN
- Defined:
  - Adds input port SyncIn (1 bit).
  - A SyncIn pulse forces every RUN channel to Cnt<=0 and ClkOut<=0 on the next cycle, and applies any pending shadow divisor (Pend<=0).
  - Tick is not asserted.
  - A truncated high phase is permitted and documented.
  - IDLE channels are unaffected except for pending-divisor apply.
  - Rst has priority over SyncIn; SyncIn has priority over the normal toggle.
- Undefined: SyncIn port is absent and there is no realignment logic.

Test Plan:
1. Reset, En=4'b0001, DEF_DIV=5 -> Run[0]=1 one cycle after En. ClkOut[0] rises 6 cycles later. Period 12 cycles with 6 high/6 low. Tick[0] high 1 cycle per 12. Channels 1..3 stay 0.
2. Ch0 running at Div=5; write WrSel=0, WrDiv=2 mid-high-phase -> Pend[0]=1. Current half still lasts 6 cycles. Then period 6 (3/3) and Pend[0]=0 at the toggle cycle.
3. Deassert En[0] two cycles into a high half at Div=5 -> ClkOut[0] stays high 4 more cycles, then goes 0. Run[0]=0 and no further Tick.
4. Write WrDiv=0 to idle ch1, then En[1]=1 -> Pend[1] clears next cycle. ClkOut[1] toggles every cycle (Clk/2) and Tick[1] pulses every 2 cycles.
5. Back-to-back writes 7 then 3 to ch2 before a toggle, plus a write with WrSel=3 when NUM_CH=3 -> ch2 applies 3 only. The out-of-range write changes nothing.
6. Assert Rst for 1 cycle mid-period with Pend set -> all outputs 0 next cycle and Div=DEF_DIV. With CLKDIV_SYNC_EN, a SyncIn pulse realigns all running channels to ClkOut=0, Cnt=0 in the same cycle.
